// File: rtl/gate_serializer_pkg.sv
// Shared state encoding and counter-width helper for the gate serializer.
// No logic, no latency, no backpressure.
package gate_serializer_pkg;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_TAIL  = 2'd2;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gap_timer.sv
// Gate pacing: tick on the cycle after start, then every gap+1 enabled cycles.
// Tick is combinational from the count; no backpressure, enable simply freezes it.
module gap_timer
    import gate_serializer_pkg::*;
#(
    parameter int gap = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic enable,
    output logic tick
);

    localparam int GW = cnt_width(gap + 1);

    logic [GW-1:0] cnt_q;
    logic [GW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == GW'(gap)) ? '0 : cnt_q + GW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = enable && (cnt_q == '0);

endmodule

// File: rtl/gate_serializer.sv
// Frame serializer: captures n_chan words on trig_in, emits one per gate, then trig_out.
// First gate one cycle after trigger; no backpressure, mid-frame triggers set sticky overrun.
module gate_serializer
    import gate_serializer_pkg::*;
#(
    parameter int dw     = 18,
    parameter int n_chan = 16,
    parameter int gap    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 trig_in,
    input  logic [dw*n_chan-1:0] data_in,
    input  logic                 clear_overrun,
    output logic                 gate_out,
    output logic [dw-1:0]        data_out,
    output logic                 trig_out,
    output logic                 busy,
    output logic                 overrun
);

    localparam int CW = cnt_width(n_chan);

    state_t               state_q, state_d;
    logic [CW-1:0]        chan_q, chan_d;
    logic [dw*n_chan-1:0] shadow_q, shadow_d;
    logic [dw-1:0]        data_q, data_d;
    logic                 overrun_q, overrun_d;
    logic                 tick;
    logic                 gate;
    logic                 accept;
    logic [dw-1:0]        word;

    assign word   = shadow_q[int'(chan_q) * dw +: dw];
    // The TAIL cycle accepts a trigger so frames can run back-to-back.
    assign accept = trig_in && (state_q == ST_IDLE || state_q == ST_TAIL);
    assign gate   = (state_q == ST_SHIFT) && tick;

    gap_timer #(.gap(gap)) u_gap_timer (
        .clk   (clk),
        .rst   (rst),
        .start (accept),
        .enable(state_q == ST_SHIFT),
        .tick  (tick)
    );

    always_comb begin
        state_d  = state_q;
        chan_d   = chan_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        case (state_q)
            ST_IDLE, ST_TAIL: begin
                if (accept) begin
                    state_d  = ST_SHIFT;
                    chan_d   = '0;
                    shadow_d = data_in;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (gate) begin
                    data_d = word;
                    if (chan_q == CW'(n_chan - 1)) begin
                        state_d = ST_TAIL;
                    end else begin
                        chan_d = chan_q + CW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A rejected trigger wins over a simultaneous clear.
        overrun_d = (trig_in && state_q == ST_SHIFT) || (overrun_q && !clear_overrun);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            chan_q    <= '0;
            shadow_q  <= '0;
            data_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            chan_q    <= chan_d;
            shadow_q  <= shadow_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
        end
    end

    assign gate_out = gate;
    assign data_out = gate ? word : data_q;
    assign trig_out = (state_q == ST_TAIL);
    assign busy     = (state_q != ST_IDLE);
    assign overrun  = overrun_q;

endmodule
